maoin_st_to_ram_writer: RTL and testbench
=========================================

// Module: maoin_st_to_ram_writer
// PURPOSE
// - Avalon-ST to Avalon-MM writer that fills the maoin on-chip RAM (32-bit, 25000 words, byte-enabled, zero-wait).
// - Sits directly upstream of the RAM's s1 write port.
// - A CPU-programmed job (base word address, length in words) pulls 32-bit beats from a stream source.
// - Beats pass through a small FIFO, are written to consecutive RAM words, and done/IRQ is raised at job end.
// PARAMETERS
// DATA_W      32     stream and RAM data width; byteenable width is DATA_W/8
// ADDR_W      15     RAM word-address width
// DEPTH       25000  RAM words; the highest legal address is DEPTH-1
// FIFO_DEPTH  4      skid FIFO entries; must be a power of 2 and >= 2
// PORTS
// clk            in   1       system clock
// reset_n        in   1       synchronous, active-low reset
// csr_address    in   2       0=BASE 1=LENGTH 2=CONTROL 3=STATUS
// csr_write      in   1       CSR write strobe
// csr_writedata  in   32      CSR write data
// csr_read       in   1       CSR read strobe
// csr_readdata   out  32      registered CSR read data; 1-cycle read latency
// snk_data       in   DATA_W  stream beat
// snk_valid      in   1       beat valid
// snk_eop        in   1       last beat of the packet
// snk_ready      out  1       sink ready
// ram_stall      in   1       RAM port unavailable (arbiter); no write is issued while high
// ram_address    out  ADDR_W  RAM word address
// ram_chipselect out  1       RAM select
// ram_write      out  1       RAM write strobe
// ram_byteenable out  DATA_W/8 always all-ones on writes
// ram_writedata  out  DATA_W  RAM write data
// irq            out  1       = done & irq_en
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge), including mid-job:
//   - FSM goes to IDLE and the FIFO is emptied.
//   - BASE, LENGTH, count, done, overflow and irq_en clear to 0.
//   - All outputs drive 0, including snk_ready, ram_write, ram_chipselect, irq and csr_readdata.
// - CSR registers:
//   - BASE[ADDR_W-1:0] and LENGTH[15:0] are writable only in IDLE or DONE; writes at other times are ignored.
//   - CONTROL: bit0 go (self-clearing), bit1 clear_done, bit2 irq_en (read back).
//   - STATUS: bit0 busy, bit1 done, bit2 overflow, bits31:16 words_written; read-only.
// - FSM IDLE -> RUN -> DRAIN -> DONE:
//   - IDLE/DONE, go=1: load addr=BASE, clear count, done and overflow; next cycle RUN.
//   - go together with clear_done: go wins (done ends cleared).
//   - go while RUN/DRAIN: ignored.
//   - LENGTH=0 with go: RUN -> DONE on the next cycle with words_written=0 and no RAM writes.
//   - RUN: snk_ready = (accepted < LENGTH) & FIFO not full & no stop pending. A beat is accepted on snk_valid & snk_ready.
//   - RUN -> DRAIN on the cycle after an accepted beat that makes accepted==LENGTH or has snk_eop=1.
//   - DRAIN: snk_ready=0. -> DONE once the FIFO is empty and the final RAM write has been issued.
//   - DONE: done=1 is held until clear_done or a new go; busy=0.
// - RAM side:
//   - FIFO pops when not empty & ~ram_stall.
//   - The popped word is registered onto ram_writedata/ram_address with ram_write=ram_chipselect=1 for exactly one cycle; addr then increments.
//   - Minimum latency: beat accepted at cycle N -> ram_write high at cycle N+2.
//   - ram_stall high: no pop, ram_write=0 and the FIFO holds its contents; the stream back-pressures when the FIFO is full.
// - Bounds: if the next write address would exceed DEPTH-1 (i.e. BASE+LENGTH > DEPTH):
//   - overflow=1 and the out-of-range write is not issued.
//   - The FIFO is flushed, the FSM goes to DONE and the stream is no longer accepted.
//   - Addresses never wrap.
// - words_written counts issued RAM writes and saturates at 0xFFFF.
// - Simultaneous FIFO push and pop on the same cycle are both honoured, with an exact occupancy count.
// STRUCTURE
// - Shared package maoin_pkg:
//   - CSR offset constants (BASE/LENGTH/CONTROL/STATUS).
//   - CONTROL/STATUS bit positions.
//   - FSM state enum.
//   - MAOIN_RAM_DEPTH=25000, MAOIN_RAM_AW=15.
// - One sub-module, maoin_sync_fifo (DATA_W x FIFO_DEPTH):
//   - push/pop/full/empty/flush; registered storage with a combinational head.
// - FSM, address/count logic and CSR file live in the top module.
// TESTING
// - Program BASE=0x0010 LENGTH=4 and go. Stream 0xA0..0xA3 with no stall:
//   - RAM words 0x10..0x13 = 0xA0..0xA3.
//   - Then DONE, STATUS=0x0004_0002, and irq=1 when irq_en=1.
// - Same job with ram_stall high for 6 cycles mid-job:
//   - snk_ready drops after 4 buffered beats.
//   - No write is issued during the stall and no data is lost or reordered.
// - LENGTH=8 with snk_eop on beat 3: 3 writes, words_written=3, snk_ready=0 afterwards.
// - BASE=24998 LENGTH=4: writes to 24998 and 24999 only, then overflow=1, DONE, words_written=2.
// - Assert reset_n=0 mid-RUN with 2 words in the FIFO: on the next cycle all outputs are 0 and STATUS=0; a new go starts cleanly.
// - CSR checks: go while busy is ignored; LENGTH=0 with go gives DONE with zero writes; go with clear_done together leaves done=0 and busy=1.

Source files
------------

// File: rtl/maoin_pkg.sv
// Shared definitions for the maoin stream-to-RAM writer.
// Contents: CSR offsets, CONTROL/STATUS bit positions, FSM state encoding,
// RAM geometry constants and a saturating counter helper.
package maoin_pkg;

  localparam int MAOIN_RAM_DEPTH = 25000;
  localparam int MAOIN_RAM_AW    = 15;

  localparam logic [1:0] CSR_BASE    = 2'd0;
  localparam logic [1:0] CSR_LENGTH  = 2'd1;
  localparam logic [1:0] CSR_CONTROL = 2'd2;
  localparam logic [1:0] CSR_STATUS  = 2'd3;

  localparam int CTRL_GO         = 0;
  localparam int CTRL_CLEAR_DONE = 1;
  localparam int CTRL_IRQ_EN     = 2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_WORDS_LSB = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/maoin_sync_fifo.sv
// Small synchronous FIFO used as the skid buffer between the stream sink and
// the RAM write port. Registered storage, combinational head (data_o is the
// oldest entry whenever empty_o is low).
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   flush_i         drop all contents (pointers and count cleared)
//   push_i, data_i  write one entry (ignored when full)
//   pop_i           remove the head entry (ignored when empty)
//   data_o          head entry
//   full_o, empty_o occupancy flags
module maoin_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // Push and pop in the same cycle leave the count unchanged.
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/maoin_st_to_ram_writer.sv
// Avalon-ST to Avalon-MM writer filling the maoin on-chip RAM.
// A CPU job (BASE word address, LENGTH in words) pulls beats from the stream
// sink through a skid FIFO and writes them to consecutive RAM words, then
// raises done (and irq when enabled).
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   csr_*                         register file (BASE/LENGTH/CONTROL/STATUS),
//                                 read data registered, 1-cycle latency
//   snk_data/valid/eop/ready      stream sink
//   ram_stall                     RAM port busy, holds off writes
//   ram_address/chipselect/write/byteenable/writedata   RAM s1 write port
//   irq                           done & irq_en
//
// state    | meaning
// ST_IDLE  | no job since reset
// ST_RUN   | accepting beats and writing RAM
// ST_DRAIN | stream closed, emptying FIFO into RAM
// ST_DONE  | job finished (or stopped on address overflow)
module maoin_st_to_ram_writer
  import maoin_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = MAOIN_RAM_AW,
  parameter int DEPTH      = MAOIN_RAM_DEPTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          csr_address,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  input  logic                csr_read,
  output logic [31:0]         csr_readdata,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  input  logic                snk_eop,
  output logic                snk_ready,
  input  logic                ram_stall,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                irq
);
  // One extra address bit so the pointer can step past the last word
  // without wrapping back to low memory.
  localparam int AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] LAST_ADDR = AW1'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       length_q, accepted_q, count_q;
  logic [AW1-1:0]    addr_q;
  logic              done_q, overflow_q, irq_en_q;
  logic              ram_write_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic [DATA_W-1:0] ram_writedata_q;
  logic [31:0]       csr_readdata_q, csr_rdata_d;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              cfg_ok, ctrl_wr, go, busy, active;
  logic              pop_req, out_of_range, wr_issue, ovf_hit, accept;
  logic              unused_csr_wdata;

  assign cfg_ok  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign ctrl_wr = csr_write && (csr_address == CSR_CONTROL);
  assign go      = ctrl_wr && csr_writedata[CTRL_GO] && cfg_ok;
  assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign busy    = active;

  assign pop_req      = active && !fifo_empty && !ram_stall;
  assign out_of_range = (addr_q > LAST_ADDR);
  assign wr_issue     = pop_req && !out_of_range;
  assign ovf_hit      = pop_req && out_of_range;

  // ovf_hit closes the stream in the same cycle the FSM decides to stop.
  assign snk_ready = (state_q == ST_RUN) && (accepted_q < length_q)
                     && !fifo_full && !ovf_hit;
  assign accept    = snk_valid && snk_ready;

  assign unused_csr_wdata = ^csr_writedata[31:16];

  maoin_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (ovf_hit),
    .push_i  (accept),
    .data_i  (snk_data),
    .pop_i   (wr_issue),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    csr_rdata_d = '0;
    case (csr_address)
      CSR_BASE:    csr_rdata_d[ADDR_W-1:0] = base_q;
      CSR_LENGTH:  csr_rdata_d[15:0]       = length_q;
      CSR_CONTROL: csr_rdata_d[CTRL_IRQ_EN] = irq_en_q;
      default: begin
        csr_rdata_d[STAT_BUSY]     = busy;
        csr_rdata_d[STAT_DONE]     = done_q;
        csr_rdata_d[STAT_OVERFLOW] = overflow_q;
        csr_rdata_d[STAT_WORDS_LSB +: 16] = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      length_q        <= '0;
      accepted_q      <= '0;
      count_q         <= '0;
      addr_q          <= '0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      irq_en_q        <= 1'b0;
      ram_write_q     <= 1'b0;
      ram_address_q   <= '0;
      ram_writedata_q <= '0;
      csr_readdata_q  <= '0;
    end else begin
      ram_write_q <= wr_issue;
      if (wr_issue) begin
        ram_address_q   <= addr_q[ADDR_W-1:0];
        ram_writedata_q <= fifo_head;
        addr_q          <= addr_q + 1'b1;
        count_q         <= sat_inc16(count_q);
      end
      if (accept) accepted_q <= accepted_q + 16'd1;

      if (csr_write && cfg_ok) begin
        if (csr_address == CSR_BASE)   base_q   <= csr_writedata[ADDR_W-1:0];
        if (csr_address == CSR_LENGTH) length_q <= csr_writedata[15:0];
      end
      if (ctrl_wr) begin
        irq_en_q <= csr_writedata[CTRL_IRQ_EN];
        if (csr_writedata[CTRL_CLEAR_DONE]) done_q <= 1'b0;
      end
      if (csr_read) csr_readdata_q <= csr_rdata_d;

      // Later assignments below override clear_done, so go always wins.
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state_q    <= ST_RUN;
            addr_q     <= {1'b0, base_q};
            count_q    <= '0;
            accepted_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ovf_hit) begin
            state_q    <= ST_DONE;
            overflow_q <= 1'b1;
            done_q     <= 1'b1;
          end else if (length_q == 16'd0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (accept && ((accepted_q + 16'd1 == length_q) || snk_eop)) begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          if (ovf_hit) begin
            state_q    <= ST_DONE;
            overflow_q <= 1'b1;
            done_q     <= 1'b1;
          end else if (fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign csr_readdata   = csr_readdata_q;
  assign ram_write      = ram_write_q;
  assign ram_chipselect = ram_write_q;
  assign ram_byteenable = {(DATA_W/8){ram_write_q}};
  assign ram_address    = ram_address_q;
  assign ram_writedata  = ram_writedata_q;
  assign irq            = done_q & irq_en_q;

endmodule

// File: tb/tb_maoin_st_to_ram_writer.sv
module tb_maoin_st_to_ram_writer;
  import maoin_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  csr_address;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic        csr_read;
  logic [31:0] csr_readdata;
  logic [31:0] snk_data;
  logic        snk_valid;
  logic        snk_eop;
  logic        snk_ready;
  logic        ram_stall;
  logic [14:0] ram_address;
  logic        ram_chipselect;
  logic        ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata;
  logic        irq;

  maoin_st_to_ram_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_read       (csr_read),
    .csr_readdata   (csr_readdata),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_eop        (snk_eop),
    .snk_ready      (snk_ready),
    .ram_stall      (ram_stall),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          base;
    int          len;
    int          n_beats;
    int          eop_idx;
    int          st_s;
    int          st_n;
    bit          irq_en;
    int          d0;
    int          exp_wr;
    logic [31:0] exp_status;
    int          exp_lat;
    int          ready_low_cyc;
  } job_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int first_acc, first_wr, ready_after_stop, wr_in_stall, be_bad;
  logic rl_val;

  function automatic job_t mk(int base, int len, int nb, int eop, int sts, int stn,
                              bit ie, int d0, int ew, logic [31:0] es, int lat, int rlc);
    job_t j;
    j.base = base; j.len = len; j.n_beats = nb; j.eop_idx = eop;
    j.st_s = sts; j.st_n = stn; j.irq_en = ie; j.d0 = d0;
    j.exp_wr = ew; j.exp_status = es; j.exp_lat = lat; j.ready_low_cyc = rlc;
    return j;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(negedge clk);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // Drives the stream for a fixed cycle budget starting in the first RUN cycle,
  // logging RAM writes and protocol observations.
  task automatic run_stream(input job_t j);
    int  beat = 0;
    bit  stopped = 1'b0;
    bit  prev_stall = 1'b0;
    log_addr.delete(); log_data.delete();
    first_acc = -1; first_wr = -1;
    ready_after_stop = 0; wr_in_stall = 0; be_bad = 0; rl_val = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      ram_stall = (cyc >= j.st_s) && (cyc < j.st_s + j.st_n);
      snk_valid = (beat < j.n_beats);
      snk_data  = 32'(j.d0 + beat);
      snk_eop   = (beat == j.eop_idx);
      #1;
      if (ram_write) begin
        log_addr.push_back(32'(ram_address));
        log_data.push_back(ram_writedata);
        if (prev_stall) wr_in_stall++;
        if (ram_byteenable !== 4'hF || ram_chipselect !== 1'b1) be_bad++;
        if (first_wr < 0) first_wr = cyc;
      end
      if (cyc == j.ready_low_cyc) rl_val = snk_ready;
      if (stopped && snk_ready) ready_after_stop++;
      if (snk_valid && snk_ready) begin
        if (first_acc < 0) first_acc = cyc;
        if (snk_eop) stopped = 1'b1;
        beat++;
        if (beat == j.len) stopped = 1'b1;
      end
      prev_stall = ram_stall;
      @(negedge clk);
    end
    snk_valid = 1'b0; snk_eop = 1'b0; ram_stall = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    csr_wr(CSR_BASE, 32'(j.base));
    csr_wr(CSR_LENGTH, 32'(j.len));
    csr_wr(CSR_CONTROL, j.irq_en ? 32'h5 : 32'h1);
    run_stream(j);
  endtask

  task automatic check_job(input job_t j, input string tag);
    logic [31:0] rd;
    chk({tag, "_writes"}, 32'(log_addr.size()), 32'(j.exp_wr));
    for (int k = 0; k < j.exp_wr && k < log_addr.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), log_addr[k], 32'(j.base + k));
      chk($sformatf("%s_data%0d", tag, k), log_data[k], 32'(j.d0 + k));
    end
    csr_rd(CSR_STATUS, rd);
    chk({tag, "_status"}, rd, j.exp_status);
    chk({tag, "_irq"}, 32'(irq), 32'(j.irq_en));
    chk({tag, "_ready_after_stop"}, 32'(ready_after_stop), 32'd0);
    chk({tag, "_write_in_stall"}, 32'(wr_in_stall), 32'd0);
    chk({tag, "_byteenable"}, 32'(be_bad), 32'd0);
    if (j.exp_lat > 0) chk({tag, "_latency"}, 32'(first_wr - first_acc), 32'(j.exp_lat));
    if (j.ready_low_cyc >= 0) chk({tag, "_ready_full"}, 32'(rl_val), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    job_t        jobs[7];
    job_t        h;
    logic [31:0] rd;

    jobs[0] = mk(32'h10,  4, 4, -1, 0, 0, 1'b1, 32'hA0, 4, 32'h0004_0002, 2, -1);
    jobs[1] = mk(32'h10,  8, 8, -1, 0, 6, 1'b0, 32'hC0, 8, 32'h0008_0002, 0,  4);
    jobs[2] = mk(32'h100, 8, 8,  2, 0, 0, 1'b0, 32'hB0, 3, 32'h0003_0002, 2, -1);
    jobs[3] = mk(24998,   4, 4, -1, 0, 0, 1'b0, 32'h50, 2, 32'h0002_0006, 2, -1);
    jobs[4] = mk(32'h20,  0, 0, -1, 0, 0, 1'b1, 32'h60, 0, 32'h0000_0002, 0, -1);
    jobs[5] = mk(32'h7FFF,2, 2, -1, 0, 0, 1'b0, 32'h70, 0, 32'h0000_0006, 0, -1);
    jobs[6] = mk(24996,   4, 4, -1, 0, 0, 1'b0, 32'h80, 4, 32'h0004_0002, 2, -1);

    reset_n = 1'b0; csr_address = '0; csr_write = 1'b0; csr_writedata = '0;
    csr_read = 1'b0; snk_data = '0; snk_valid = 1'b0; snk_eop = 1'b0; ram_stall = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    chk("rst_ram_write", 32'(ram_write), 32'd0);
    chk("rst_snk_ready", 32'(snk_ready), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_readdata", csr_readdata, 32'd0);
    csr_rd(CSR_STATUS, rd);  chk("rst_status", rd, 32'd0);
    csr_rd(CSR_BASE, rd);    chk("rst_base", rd, 32'd0);
    csr_rd(CSR_LENGTH, rd);  chk("rst_length", rd, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_job(jobs[i]);
      check_job(jobs[i], $sformatf("job%0d", i));
    end

    // go together with clear_done while done=1; then writes while busy are ignored
    csr_wr(CSR_BASE, 32'h40);
    csr_wr(CSR_LENGTH, 32'd4);
    csr_wr(CSR_CONTROL, 32'h3);
    csr_rd(CSR_STATUS, rd);  chk("goclr_status", rd, 32'h0000_0001);
    csr_wr(CSR_BASE, 32'h55);
    csr_wr(CSR_CONTROL, 32'h1);
    csr_rd(CSR_BASE, rd);    chk("busy_base_kept", rd, 32'h40);
    h = mk(32'h40, 4, 4, -1, 0, 0, 1'b0, 32'hD0, 4, 32'h0004_0002, 2, -1);
    run_stream(h);
    check_job(h, "busy");

    // irq enable / clear_done while DONE
    csr_wr(CSR_CONTROL, 32'h4);
    chk("irq_on", 32'(irq), 32'd1);
    csr_wr(CSR_CONTROL, 32'h6);
    chk("irq_cleared", 32'(irq), 32'd0);
    csr_rd(CSR_STATUS, rd);  chk("clr_status", rd, 32'h0004_0000);
    csr_rd(CSR_CONTROL, rd); chk("ctrl_readback", rd, 32'h4);

    // reset in the middle of a job with two words buffered
    csr_wr(CSR_BASE, 32'h200);
    csr_wr(CSR_LENGTH, 32'd8);
    csr_wr(CSR_CONTROL, 32'h1);
    csr_rd(CSR_STATUS, rd);  chk("mid_busy", rd, 32'h0000_0001);
    ram_stall = 1'b1; snk_valid = 1'b1; snk_data = 32'hE0;
    @(negedge clk);
    snk_data = 32'hE1;
    @(negedge clk);
    reset_n = 1'b0; snk_data = 32'hE2;
    @(negedge clk);
    #1;
    chk("mrst_ram_write", 32'(ram_write), 32'd0);
    chk("mrst_chipselect", 32'(ram_chipselect), 32'd0);
    chk("mrst_byteenable", 32'(ram_byteenable), 32'd0);
    chk("mrst_address", 32'(ram_address), 32'd0);
    chk("mrst_writedata", ram_writedata, 32'd0);
    chk("mrst_snk_ready", 32'(snk_ready), 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);
    chk("mrst_readdata", csr_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; snk_valid = 1'b0; ram_stall = 1'b0;
    csr_rd(CSR_STATUS, rd);  chk("mrst_status", rd, 32'd0);
    csr_rd(CSR_BASE, rd);    chk("mrst_base", rd, 32'd0);
    csr_rd(CSR_LENGTH, rd);  chk("mrst_length", rd, 32'd0);
    csr_rd(CSR_CONTROL, rd); chk("mrst_control", rd, 32'd0);
    h = mk(32'h30, 2, 2, -1, 0, 0, 1'b0, 32'hF0, 2, 32'h0002_0002, 2, -1);
    run_job(h);
    check_job(h, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
